// File: rtl/d_mem_dma.sv
// d_mem_dma: data-memory block copy/fill master; D_MEM_DMA_CHECKSUM_EN adds a sum of written words
module d_mem_dma #(
  parameter int AW = 8,
  parameter int DW = 16,
  parameter int LW = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          mode,
  input  logic [AW-1:0] src,
  input  logic [AW-1:0] dst,
  input  logic [LW-1:0] len,
  input  logic [DW-1:0] fill_val,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_dwe,
`ifdef D_MEM_DMA_CHECKSUM_EN
  output logic [DW-1:0] checksum,
`endif
  input  logic [DW-1:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, RD, WR, FIN} state_t;
  state_t state, state_n;
  logic [AW-1:0] sptr, sptr_n, dptr, dptr_n, addr_n;
  logic [LW-1:0] cnt, cnt_n, len_c;
  logic [DW-1:0] wdata_n;
  logic mode_r, mode_n, dwe_n;
  assign len_c = (len > LW'(1 << AW)) ? LW'(1 << AW) : len;
  always_comb begin
    state_n = state;
    sptr_n = sptr;
    dptr_n = dptr;
    cnt_n = cnt;
    mode_n = mode_r;
    addr_n = mem_addr;
    wdata_n = mem_wdata;
    dwe_n = 1'b0;
    case (state)
      IDLE: if (start) begin
        sptr_n = src;
        dptr_n = dst;
        cnt_n = len_c;
        mode_n = mode;
        if (len == '0) state_n = FIN;
        else if (mode) begin
          state_n = WR;
          addr_n = dst;
          wdata_n = fill_val;
          dwe_n = 1'b1;
        end else begin
          state_n = RD;
          addr_n = src;
        end
      end
      RD: begin
        wdata_n = mem_rdata;
        addr_n = dptr;
        dwe_n = 1'b1;
        sptr_n = sptr + AW'(1);
        state_n = WR;
      end
      WR: begin
        dptr_n = dptr + AW'(1);
        cnt_n = cnt - LW'(1);
        if (cnt == LW'(1)) state_n = FIN;
        else if (mode_r) begin
          addr_n = dptr + AW'(1);
          dwe_n = 1'b1;
        end else begin
          addr_n = sptr;
          state_n = RD;
        end
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sptr <= '0;
      dptr <= '0;
      cnt <= '0;
      mode_r <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      mem_dwe <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      sptr <= sptr_n;
      dptr <= dptr_n;
      cnt <= cnt_n;
      mode_r <= mode_n;
      mem_addr <= addr_n;
      mem_wdata <= wdata_n;
      mem_dwe <= dwe_n;
      busy <= state_n == RD || state_n == WR;
      done <= state == FIN;
    end
  end
`ifdef D_MEM_DMA_CHECKSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) checksum <= '0;
    else if (state == IDLE && start) checksum <= '0;
    else if (state == WR) checksum <= checksum + mem_wdata;
  end
`endif
endmodule
